// File: rtl/dmem_arb_pkg.sv
// Shared constants and response-FSM encoding for the data memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DMA  = 1;

  localparam int unsigned BE_W = 4;

  typedef logic [1:0] rsp_state_t;

  localparam rsp_state_t IDLE = 2'd0;
  localparam rsp_state_t RSP0 = 2'd1;
  localparam rsp_state_t RSP1 = 2'd2;

endpackage

// File: rtl/dmem_arb_age_counter.sv
// Saturating wait counter for the DMA port; limit_hit forces that port to win.
module dmem_arb_age_counter #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !limit_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with registered read return.
// Define DMEM_ARB_RR_EN for round-robin priority instead of fixed priority plus starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
`ifndef DMEM_ARB_RR_EN
  parameter int unsigned STARVE_LIMIT = 8,
`endif
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic [BE_W-1:0] m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic [BE_W-1:0] m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic [BE_W-1:0] mem_we,
  input  logic [DW-1:0]   mem_dout
);

  logic       m1_prio;
  logic       gnt0, gnt1;
  logic       rd0, rd1;
  rsp_state_t state_q, state_d;
  logic [DW-1:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_RR_EN
  // High once port 0 took the latest grant; the reset value hands the first tie to the DMA port.
  logic last_gnt_q, last_gnt_d;

  assign m1_prio = last_gnt_q;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = 1'b1;
    end else if (gnt1) begin
      last_gnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  dmem_arb_age_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_age_counter (
    .clk       (clk),
    .reset     (reset),
    .inc       (m1_req && !gnt1),
    .clr       (!m1_req || gnt1),
    .limit_hit (m1_prio)
  );
`endif

  // Grants are gated by reset so nothing reaches the memory while it is held.
  always_comb begin
    gnt1 = !reset && m1_req && (!m0_req || m1_prio);
    gnt0 = !reset && m0_req && !gnt1;
    rd0  = gnt0 && (m0_we == '0);
    rd1  = gnt1 && (m1_we == '0);
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = '0;
    if (gnt0) begin
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
      mem_we   = m0_we;
    end else if (gnt1) begin
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
      mem_we   = m1_we;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (rd0) begin
      state_d = RSP0;
    end else if (rd1) begin
      state_d = RSP1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd0) begin
        rdata0_q <= mem_dout;
      end
      if (rd1) begin
        rdata1_q <= mem_dout;
      end
    end
  end

  assign m0_rvalid = (state_q == RSP0);
  assign m1_rvalid = (state_q == RSP1);
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter in its default fixed-priority build.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [3:0]  m0_we, m1_we, mem_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout)
  );

  typedef struct {
    logic        m0_req;
    logic [3:0]  m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic [3:0]  m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] dout;
    logic        g0;
    logic        g1;
    logic [3:0]  mwe;
    logic [31:0] maddr;
    logic [31:0] mdin;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic [3:0] w1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] dout);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    mem_dout = dout;
  endtask

  initial begin
    // m0 req/we/addr/wdata, m1 req/we/addr/wdata, dout | gnt0 gnt1 mem_we/addr/din | rv0 rd0 rv1 rd1
    vecs[0] = '{1, 4'h0, 32'h10, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                1, 0, 4'h0, 32'h10, 32'h0, 0, 32'h0, 0, 32'h0};
    vecs[1] = '{0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h55555555,
                0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[2] = '{0, 4'h0, 32'h0, 32'h0, 1, 4'h3, 32'h20, 32'h1234, 32'h66666666,
                0, 1, 4'h3, 32'h20, 32'h1234, 0, 32'hDEADBEEF, 0, 32'h0};
    vecs[3] = '{0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0};
    vecs[4] = '{1, 4'h0, 32'h4, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'hAAAA0001,
                1, 0, 4'h0, 32'h4, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0};
    vecs[5] = '{0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h8, 32'h0, 32'hBBBB0002,
                0, 1, 4'h0, 32'h8, 32'h0, 1, 32'hAAAA0001, 0, 32'h0};
    vecs[6] = '{1, 4'hF, 32'h30, 32'hCAFE, 1, 4'h0, 32'h40, 32'h0, 32'h11111111,
                1, 0, 4'hF, 32'h30, 32'hCAFE, 0, 32'hAAAA0001, 1, 32'hBBBB0002};
    vecs[7] = '{1, 4'h4, 32'h31, 32'h00AB0000, 1, 4'hF, 32'h99, 32'h77, 32'h22222222,
                1, 0, 4'h4, 32'h31, 32'h00AB0000, 0, 32'hAAAA0001, 0, 32'hBBBB0002};
    vecs[8] = '{0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0,
                0, 0, 4'h0, 32'h0, 32'h0, 0, 32'hAAAA0001, 0, 32'hBBBB0002};

    // Reset with a live request: nothing may be granted.
    reset = 1'b1;
    drive(1, 4'hF, 32'h44, 32'h55, 1, 4'hF, 32'h66, 32'h77, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    check("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst_rdata0", m0_rdata, 32'd0);
    check("rst_rdata1", m1_rdata, 32'd0);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
            vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata, vecs[i].dout);
      #2;
      check($sformatf("v%0d_gnt0", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
      check($sformatf("v%0d_gnt1", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
      check($sformatf("v%0d_mem_we", i), {28'd0, mem_we}, {28'd0, vecs[i].mwe});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
      check($sformatf("v%0d_mem_din", i), mem_din, vecs[i].mdin);
      check($sformatf("v%0d_rvalid0", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].rv0});
      check($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].rd0);
      check($sformatf("v%0d_rvalid1", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].rv1});
      check($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].rd1);
    end

    // Both ports reading every cycle: port 1 forced through on cycles 8 and 17.
    for (int i = 0; i < 20; i++) begin
      logic exp_g1, prev_g1;
      exp_g1  = (i == 8) || (i == 17);
      prev_g1 = (i == 9) || (i == 18);
      @(negedge clk);
      drive(1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h200, 32'h0, 32'h1000 + i);
      #2;
      check($sformatf("st%0d_gnt0", i), {31'd0, m0_gnt}, {31'd0, !exp_g1});
      check($sformatf("st%0d_gnt1", i), {31'd0, m1_gnt}, {31'd0, exp_g1});
      check($sformatf("st%0d_mem_addr", i), mem_addr, exp_g1 ? 32'h200 : 32'h100);
      check($sformatf("st%0d_rvalid1", i), {31'd0, m1_rvalid}, {31'd0, prev_g1});
      check($sformatf("st%0d_rvalid0", i), {31'd0, m0_rvalid}, {31'd0, (i > 0) && !prev_g1});
      if (i == 9) check("st9_rdata1", m1_rdata, 32'h1008);
      if (i == 18) check("st18_rdata1", m1_rdata, 32'h1011);
      if (i == 8) check("st8_rdata0", m0_rdata, 32'h1007);
    end

    // Read granted, then reset lands while its response is due.
    @(negedge clk);
    drive(1, 4'h0, 32'h50, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h00000077);
    #2;
    check("rr_gnt0", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 4'hF, 32'h54, 32'hFFFF, 1, 4'hF, 32'h58, 32'hEEEE, 32'h0);
    #2;
    check("rr_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    check("rr_rdata0", m0_rdata, 32'd0);
    check("rr_rdata1", m1_rdata, 32'd0);
    check("rr_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
    check("rr_mem_we", {28'd0, mem_we}, 32'd0);
    @(negedge clk);
    #2;
    check("rr_hold_mem_we", {28'd0, mem_we}, 32'd0);
    check("rr_hold_rvalid0", {31'd0, m0_rvalid}, 32'd0);
    reset = 1'b0;
    drive(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2;
    check("rr_post_rvalid0", {31'd0, m0_rvalid}, 32'd0);

    // Normal read after reset recovers.
    @(negedge clk);
    drive(1, 4'h0, 32'h60, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h00000099);
    #2;
    check("pr_gnt0", {31'd0, m0_gnt}, 32'd1);
    @(negedge clk);
    drive(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    #2;
    check("pr_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    check("pr_rdata0", m0_rdata, 32'h99);
    @(negedge clk);
    #2;
    check("pr_rvalid0_drop", {31'd0, m0_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
